// File: rtl/sram_share_arbiter.sv
// sram_share_arbiter
//   Shares one single-port, read-first SRAM (1-cycle read latency) between two
//   requesters. Port 0 (FSMC bridge) has priority; port 1 (internal master) is
//   guaranteed a grant after MAX_WAIT consecutive blocked cycles.
//
// Ports
//   aclk, areset                 clock, asynchronous active-high reset
//   pX_valid / pX_ready          command handshake (transfer on valid & ready)
//   pX_addr, pX_wen, pX_wdata    command payload; pX_wen == 0 means read
//   pX_rvalid, pX_rdata          read response, two cycles after acceptance
//   sram_en, sram_wen,
//   sram_addr, sram_din          registered SRAM command
//   sram_dout                    SRAM read data, valid one cycle after read edge
module sram_share_arbiter #(
   parameter  int ADDR_WIDTH = 16,
   parameter  int DATA_WIDTH = 16,
   parameter  int MAX_WAIT   = 4,
   parameter  int CNT_WIDTH  = 4,
   localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  p0_valid,
   output logic                  p0_ready,
   input  logic [ADDR_WIDTH-1:0] p0_addr,
   input  logic [BE_WIDTH-1:0]   p0_wen,
   input  logic [DATA_WIDTH-1:0] p0_wdata,
   output logic                  p0_rvalid,
   output logic [DATA_WIDTH-1:0] p0_rdata,
   input  logic                  p1_valid,
   output logic                  p1_ready,
   input  logic [ADDR_WIDTH-1:0] p1_addr,
   input  logic [BE_WIDTH-1:0]   p1_wen,
   input  logic [DATA_WIDTH-1:0] p1_wdata,
   output logic                  p1_rvalid,
   output logic [DATA_WIDTH-1:0] p1_rdata,
   output logic                  sram_en,
   output logic [BE_WIDTH-1:0]   sram_wen,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WAIT);

   logic [CNT_WIDTH-1:0]  wait_cnt;
   logic                  force1;
   logic                  accept;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [BE_WIDTH-1:0]   win_wen;
   logic [DATA_WIDTH-1:0] win_wdata;
   logic                  rd_pend_p1;
   logic                  rd_src_p1;
   logic [DATA_WIDTH-1:0] rdata0_hold;
   logic [DATA_WIDTH-1:0] rdata1_hold;

   // ---- Stage 0: combinational arbitration ----
   // Each ready is written purely from the valids and wait_cnt so that
   // neither ready is derived from the other one.
   assign force1   = (wait_cnt == MAX_CNT);
   assign p1_ready = p1_valid & (force1 | ~p0_valid);
   assign p0_ready = p0_valid & ~(p1_valid & force1);
   assign accept   = p0_ready | p1_ready;

   always_comb begin
      win_addr  = p0_addr;
      win_wen   = p0_wen;
      win_wdata = p0_wdata;
      if (p1_ready) begin
         win_addr  = p1_addr;
         win_wen   = p1_wen;
         win_wdata = p1_wdata;
      end
   end

   // Blocked cycles of port 1 are counted only while it keeps asking.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wait_cnt <= '0;
      end else if (!p1_valid || p1_ready) begin
         wait_cnt <= '0;
      end else if (!force1) begin
         wait_cnt <= wait_cnt + 1'b1;
      end
   end

   // ---- Stage 1: registered SRAM command ----
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         sram_en    <= 1'b0;
         sram_wen   <= '0;
         sram_addr  <= '0;
         sram_din   <= '0;
         rd_pend_p1 <= 1'b0;
         rd_src_p1  <= 1'b0;
      end else if (accept) begin
         sram_en    <= 1'b1;
         sram_wen   <= win_wen;
         sram_addr  <= win_addr;
         sram_din   <= win_wdata;
         rd_pend_p1 <= (win_wen == '0);
         rd_src_p1  <= p1_ready;
      end else begin
         sram_en    <= 1'b0;
         sram_wen   <= '0;
         rd_pend_p1 <= 1'b0;
      end
   end

   // ---- Stage 2: response routing ----
   // rvalid is registered; the SRAM output is only valid during the response
   // cycle, so it is passed straight through then and captured for holding.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
      end else begin
         p0_rvalid <= rd_pend_p1 & ~rd_src_p1;
         p1_rvalid <= rd_pend_p1 &  rd_src_p1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         rdata0_hold <= '0;
         rdata1_hold <= '0;
      end else begin
         if (p0_rvalid) rdata0_hold <= sram_dout;
         if (p1_rvalid) rdata1_hold <= sram_dout;
      end
   end

   assign p0_rdata = p0_rvalid ? sram_dout : rdata0_hold;
   assign p1_rdata = p1_rvalid ? sram_dout : rdata1_hold;

endmodule

// File: tb/tb_sram_share_arbiter.sv
module tb_sram_share_arbiter;
   localparam int AW = 16;
   localparam int DW = 16;
   localparam int BW = 2;
   localparam int MW = 4;

   logic          aclk   = 1'b0;
   logic          areset = 1'b1;
   logic          p0_valid = 1'b0, p1_valid = 1'b0;
   logic          p0_ready, p1_ready;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0;
   logic [BW-1:0] p0_wen = '0, p1_wen = '0;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0;
   logic          p0_rvalid, p1_rvalid;
   logic [DW-1:0] p0_rdata, p1_rdata;
   logic          sram_en;
   logic [BW-1:0] sram_wen;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_din;
   logic [DW-1:0] sram_dout = '0;

   int n_assert = 0;
   int n_fail   = 0;

   sram_share_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(MW), .CNT_WIDTH(4)
   ) dut (
      .aclk(aclk), .areset(areset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_addr(p0_addr), .p0_wen(p0_wen),
      .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_addr(p1_addr), .p1_wen(p1_wen),
      .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_din(sram_din), .sram_dout(sram_dout)
   );

   always #5 aclk = ~aclk;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                           input logic [DW-1:0] wd,
                                           input logic [BW-1:0] be);
      logic [DW-1:0] r;
      r = old;
      for (int b = 0; b < BW; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   // SRAM model: single port, read-first, one cycle read latency
   logic [DW-1:0] mem     [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   always @(posedge aclk) begin
      if (sram_en) begin
         sram_dout       <= mem[sram_addr];
         mem[sram_addr]  <= merge(mem[sram_addr], sram_din, sram_wen);
      end
   end

   // Reference model state
   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } resp_t;
   resp_t         rq[$];
   int            cyc = 0;
   int            m_wait = 0;
   bit            last_acc0 = 0, last_acc1 = 0;
   logic          exp_en = 0;
   logic [BW-1:0] exp_wen = '0;
   logic [AW-1:0] exp_addr = '0;
   logic [DW-1:0] exp_din = '0;
   logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_sram_en"},   32'(sram_en),   0);
      chk({tag, "_sram_wen"},  32'(sram_wen),  0);
      chk({tag, "_sram_addr"}, 32'(sram_addr), 0);
      chk({tag, "_sram_din"},  32'(sram_din),  0);
      chk({tag, "_rvalid"},    32'({p0_rvalid, p1_rvalid}), 0);
      chk({tag, "_p0_rdata"},  32'(p0_rdata),  0);
      chk({tag, "_p1_rdata"},  32'(p1_rdata),  0);
   endtask

   task automatic model_reset();
      rq.delete();
      m_wait   = 0;
      exp_en   = 0;
      exp_wen  = '0;
      exp_addr = '0;
      exp_din  = '0;
      exp_rd0  = '0;
      exp_rd1  = '0;
      last_acc0 = 0;
      last_acc1 = 0;
   endtask

   // One clock cycle: inputs must already be driven.
   task automatic tick();
      bit            e0, e1, x0, x1;
      resp_t         r;
      logic [AW-1:0] a;
      logic [BW-1:0] w;
      logic [DW-1:0] d;
      @(negedge aclk);
      e1 = p1_valid && ((m_wait == MW) || !p0_valid);
      e0 = p0_valid && !e1;
      chk("p0_ready", 32'(p0_ready), 32'(e0));
      chk("p1_ready", 32'(p1_ready), 32'(e1));
      chk("one_ready", 32'(p0_ready & p1_ready), 0);
      x0 = 0;
      x1 = 0;
      if (rq.size() != 0 && rq[0].due == cyc) begin
         r = rq.pop_front();
         if (r.port == 0) begin x0 = 1; exp_rd0 = r.data; end
         else             begin x1 = 1; exp_rd1 = r.data; end
      end
      chk("p0_rvalid", 32'(p0_rvalid), 32'(x0));
      chk("p1_rvalid", 32'(p1_rvalid), 32'(x1));
      chk("p0_rdata",  32'(p0_rdata),  32'(exp_rd0));
      chk("p1_rdata",  32'(p1_rdata),  32'(exp_rd1));
      chk("sram_en",   32'(sram_en),   32'(exp_en));
      chk("sram_wen",  32'(sram_wen),  32'(exp_wen));
      chk("sram_addr", 32'(sram_addr), 32'(exp_addr));
      chk("sram_din",  32'(sram_din),  32'(exp_din));
      if (e0 || e1) begin
         a = e1 ? p1_addr : p0_addr;
         w = e1 ? p1_wen : p0_wen;
         d = e1 ? p1_wdata : p0_wdata;
         exp_en = 1; exp_wen = w; exp_addr = a; exp_din = d;
         if (w == '0) rq.push_back('{due: cyc + 2, port: (e1 ? 1 : 0), data: ref_mem[a]});
         else         ref_mem[a] = merge(ref_mem[a], d, w);
      end else begin
         exp_en  = 0;
         exp_wen = '0;
      end
      if (p1_valid && !e1) m_wait = (m_wait < MW) ? m_wait + 1 : MW;
      else                 m_wait = 0;
      last_acc0 = e0;
      last_acc1 = e1;
      cyc++;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int n);
      p0_valid = 0;
      p1_valid = 0;
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[5] = 16'hA55A;  ref_mem[5] = 16'hA55A;
      mem[16] = 16'hFFFF; ref_mem[16] = 16'hFFFF;
      mem[3] = 16'h0000;  ref_mem[3] = 16'h0000;

      // Reset state, with both ports requesting
      p0_valid = 1; p1_valid = 1;
      #3;
      check_zero("reset");
      @(posedge aclk); @(posedge aclk); #1;
      check_zero("reset_held");
      chk("reset_wait_cnt", 32'(dut.wait_cnt), 0);
      p0_valid = 0; p1_valid = 0;
      areset = 0;
      model_reset();
      idle(2);

      // Single read on port 0
      p0_valid = 1; p0_addr = 16'h0005; p0_wen = '0;
      tick();
      p0_valid = 0;
      chk("rd0_sram_en", 32'(sram_en), 1);
      chk("rd0_sram_addr", 32'(sram_addr), 32'h5);
      tick();
      chk("rd0_rvalid", 32'(p0_rvalid), 1);
      chk("rd0_rdata", 32'(p0_rdata), 32'hA55A);
      chk("rd0_p1_rvalid", 32'(p1_rvalid), 0);
      idle(2);

      // Byte write then read on port 1
      p1_valid = 1; p1_addr = 16'h0010; p1_wen = 2'b01; p1_wdata = 16'h1234;
      tick();
      p1_wen = 2'b00;
      tick();
      p1_valid = 0;
      tick();
      chk("bw1_rvalid", 32'(p1_rvalid), 1);
      chk("bw1_rdata", 32'(p1_rdata), 32'hFF34);
      idle(2);

      // Simultaneous requests: p0 wins 0..3, p1 forced in 4, p0 again in 5
      p0_valid = 1; p0_wen = '0; p0_addr = 16'h0020;
      p1_valid = 1; p1_wen = '0; p1_addr = 16'h0005;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("sim_p0_ready_%0d", i), 32'(p0_ready), 32'(i != 4));
         chk($sformatf("sim_p1_ready_%0d", i), 32'(p1_ready), 32'(i == 4));
         tick();
         if (i == 4) begin
            chk("sim_wait_cnt_after4", 32'(dut.wait_cnt), 0);
            p1_addr = 16'h0006;
         end else begin
            p0_addr = p0_addr + 1;
         end
      end
      idle(4);

      // Idle port 0: port 1 accepted every cycle
      for (int i = 0; i < 4; i++) begin
         p1_valid = 1; p1_addr = AW'(16'h0030 + i); p1_wen = '0;
         #1;
         chk($sformatf("pass_p1_ready_%0d", i), 32'(p1_ready), 1);
         tick();
         chk($sformatf("pass_wait_cnt_%0d", i), 32'(dut.wait_cnt), 0);
      end
      idle(3);

      // Read after write ordering across ports
      p0_valid = 1; p0_addr = 16'h0003; p0_wen = 2'b11; p0_wdata = 16'hBEEF;
      tick();
      p0_valid = 0;
      p1_valid = 1; p1_addr = 16'h0003; p1_wen = '0;
      tick();
      p1_valid = 0;
      tick();
      chk("raw_rvalid", 32'(p1_rvalid), 1);
      chk("raw_rdata", 32'(p1_rdata), 32'hBEEF);
      idle(2);

      // Reset one cycle after accepting a port 0 read
      p0_valid = 1; p0_addr = 16'h0005; p0_wen = '0;
      tick();
      p0_valid = 0;
      areset = 1;
      #1;
      check_zero("midrst");
      model_reset();
      @(posedge aclk); #1;
      check_zero("midrst_held");
      areset = 0;
      idle(4);
      p0_valid = 1; p0_addr = 16'h0005; p0_wen = '0;
      tick();
      p0_valid = 0;
      chk("post_rst_en", 32'(sram_en), 1);
      chk("post_rst_addr", 32'(sram_addr), 32'h5);
      tick();
      chk("post_rst_rvalid", 32'(p0_rvalid), 1);
      chk("post_rst_rdata", 32'(p0_rdata), 32'hA55A);
      idle(2);

      // Randomized traffic against the reference model
      last_acc0 = 0; last_acc1 = 0;
      for (int k = 0; k < 600; k++) begin
         if (!p0_valid || last_acc0) begin
            p0_valid = ($urandom_range(0, 3) != 0);
            p0_addr  = AW'($urandom_range(0, 15));
            p0_wen   = ($urandom_range(0, 1) != 0) ? BW'($urandom_range(1, 3)) : '0;
            p0_wdata = DW'($urandom);
         end
         if (!p1_valid || last_acc1) begin
            p1_valid = ($urandom_range(0, 1) != 0);
            p1_addr  = AW'($urandom_range(0, 15));
            p1_wen   = ($urandom_range(0, 1) != 0) ? BW'($urandom_range(1, 3)) : '0;
            p1_wdata = DW'($urandom);
         end
         tick();
      end
      idle(4);
      chk("resp_queue_empty", 32'(rq.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/sram_share_arbiter.md
Name: sram_share_arbiter

Overview:
- Shares one single-port SRAM (two 8-bit byte lanes, 1-cycle read latency, read-first) between two requesters.
- Port 0 is the FSMC bridge side (timing critical, high priority); port 1 is an internal master (test/DMA logic).
- Arbitrates per cycle, registers the SRAM command, and routes read data back to the issuing port.
- Starvation of port 1 is bounded by a wait counter.

Parameters:
- ADDR_WIDTH, 16, SRAM word address width.
- DATA_WIDTH, 16, data width; must be a multiple of 8. BE_WIDTH = DATA_WIDTH/8.
- MAX_WAIT, 4, consecutive cycles port 1 may be blocked before it is forced to win (range 1..15).
- CNT_WIDTH, 4, width of the port 1 wait counter; must hold MAX_WAIT.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous active-high reset.
- p0_valid  in  1  port 0 command valid.
- p0_ready  out  1  port 0 command accepted this cycle.
- p0_addr  in  ADDR_WIDTH  port 0 word address.
- p0_wen  in  BE_WIDTH  port 0 byte write enables; all-zero means read.
- p0_wdata  in  DATA_WIDTH  port 0 write data.
- p0_rvalid  out  1  port 0 read data valid (1-cycle pulse).
- p0_rdata  out  DATA_WIDTH  port 0 read data.
- p1_valid, p1_ready, p1_addr, p1_wen, p1_wdata, p1_rvalid, p1_rdata: as port 0, for port 1.
- sram_en  out  1  SRAM enable.
- sram_wen  out  BE_WIDTH  SRAM byte write enables.
- sram_addr  out  ADDR_WIDTH  SRAM address.
- sram_din  out  DATA_WIDTH  SRAM write data.
- sram_dout  in  DATA_WIDTH  SRAM read data, valid one clock after an enabled read edge.

Behaviour:
- Clocking and reset:
  - All state is on aclk; areset asserts asynchronously and releases synchronously to aclk.
  - While reset is asserted, every output is 0: sram_en, sram_wen, sram_addr, sram_din, p0/p1_rvalid, p0/p1_rdata. wait_cnt = 0.
- Handshake:
  - A command transfers when valid & ready in the same cycle.
  - ready is combinational from valid and wait_cnt; it never depends on the opposite port's ready.
  - At most one ready is high per cycle.
  - Once raised, valid and payload are held until accepted.
- Arbitration (combinational, per cycle):
  - force1 = (wait_cnt == MAX_WAIT).
  - If p1_valid & (force1 | ~p0_valid), then p1_ready = 1.
  - Else if p0_valid, then p0_ready = 1.
  - Neither valid: no grant.
- Wait counter:
  - Increments (saturating at MAX_WAIT) each cycle p1_valid is high and p1 is not accepted.
  - Clears on p1 acceptance, or whenever p1_valid = 0.
  - Worst-case p1 latency under continuous p0 traffic is MAX_WAIT cycles. After a forced grant, p0 wins again next cycle if valid.
- Command stage (registered): accept in cycle N, so in cycle N+1:
  - sram_en = 1.
  - sram_addr, sram_wen, sram_din take the winner's values.
  - rd_pend = (wen == 0) and rd_src = winner.
  - With no accept: sram_en = 0, sram_wen = 0, addr/din hold their previous values.
- Response stage:
  - In cycle N+2, pX_rvalid = 1 and pX_rdata = sram_dout for X = rd_src when rd_pend was set.
  - pX_rdata holds its last value otherwise.
  - Writes produce no response.
- Throughput and ordering:
  - One command per cycle total, full pipelining, no back-pressure on responses; requesters must always accept rvalid.
  - Back-to-back read then write to the same address: the read returns the pre-write data (ordering preserved by the single pipeline).
- Reset mid-operation: in-flight reads are discarded; no rvalid after reset release for commands accepted before reset.
- No address range checking: upper address bits pass through unchanged.

Test Plan:
- Single read, p0 only: p0 reads addr 0x0005 holding 0xA55A → p0_ready in cycle N, sram_en = 1 and sram_addr = 0x0005 in N+1, p0_rvalid = 1 and p0_rdata = 0xA55A in N+2, p1_rvalid stays 0.
- Byte write then read, p1 only: p1 writes 0x1234 with wen = 2'b01 to addr 0x0010 (prior content 0xFFFF), then reads it → p1_rdata = 0xFF34, two cycles after the read accept.
- Simultaneous request: p0 and p1 both valid at cycle 0 with MAX_WAIT = 4 → p0 wins cycles 0–3, p1_ready in cycle 4, p0 wins again in cycle 5; wait_cnt is 0 after cycle 4.
- Idle-port pass-through: p0_valid = 0, p1_valid = 1 → p1 is accepted every cycle, wait_cnt stays 0.
- Read-after-write ordering: p0 writes 0xBEEF to addr 3 (old value 0x0000), p1 reads addr 3 in the next cycle → p1_rdata = 0xBEEF; p0 reads addr 3 in the same cycle as its write → impossible by the one-grant-per-cycle rule, so check that no two readies are ever high together (assertion).
- Reset mid-flight: assert areset one cycle after accepting a p0 read → all outputs 0 immediately, no p0_rvalid after release, first new command behaves as in the single-read scenario.
